// File: rtl/spi_pump_master.sv
// ---------------------------------------------------------------------------
// spi_pump_master
//
// SPI mode-0 master that runs one "pump" transaction per start request:
//   1. PING frame : 0x00 followed by 8 more clocks; the response byte must be 0x4B.
//   2. START frame: 0x61, then len payload bytes in the same frame. Each byte
//      is fetched from the source with a byte_req_o / byte_valid_i handshake.
//   3. END frame  : 0x62 on its own.
// Between frames, SS is held high for SS_GAP cycles.
//
// Parameters
//   CLK_DIV  SCK half-period in pclk cycles (1..255)
//   SS_GAP   pclk cycles SS stays high between frames (1..255)
//
// Ports
//   pclk, reset                 clock, asynchronous active-high reset
//   start_i, len_i              transaction request and payload byte count
//   byte_i, byte_valid_i        payload byte answering byte_req_o
//   byte_req_o                  one-cycle request for the next payload byte
//   busy_o, done_o              transaction in progress / one-cycle completion pulse
//   ack_err_o, echo_err_o       sticky ping-response and echo-mismatch flags
//   bytes_sent_o                payload bytes fully shifted in this/last transaction
//   sck_o, ss_o, sdo_o, sdi_i   SPI pins (mode 0, SS active low, MSB first)
//
// Optional feature
//   SPI_PUMP_ECHO_CHECK_EN  when defined, the byte received during payload byte
//                           k (k>=1) is checked against payload byte k-1 and
//                           a mismatch sets echo_err_o. When undefined,
//                           echo_err_o is tied low.
// ---------------------------------------------------------------------------
module spi_pump_master #(
    parameter int CLK_DIV = 2,
    parameter int SS_GAP  = 4
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [18:0] len_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_req_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        ack_err_o,
    output logic        echo_err_o,
    output logic [18:0] bytes_sent_o,
    output logic        sck_o,
    output logic        ss_o,
    output logic        sdo_o,
    input  logic        sdi_i
);

    typedef enum logic [2:0] {
        IDLE, PING, START, DATA, WAIT_BYTE, END, GAP, DONE
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST  = 8'(SS_GAP - 1);
    localparam logic [7:0] PING_ACK  = 8'h4B;
    localparam logic [7:0] CMD_START = 8'h61;
    localparam logic [7:0] CMD_END   = 8'h62;

    state_t      r_state;
    state_t      w_nextState;
    state_t      r_gapNext;
    logic [18:0] r_len;
    logic [18:0] r_bytesSent;
    logic        r_ackErr;
    logic [7:0]  r_divCnt;
    logic        r_sck;
    logic [4:0]  r_bitCnt;
    logic [7:0]  r_tx;
    logic [7:0]  r_rx;
    logic        r_byteReq;
    logic [7:0]  r_gapCnt;

    logic        w_shifting;
    logic        w_halfEnd;
    logic [4:0]  w_unitBits;
    logic        w_unitDone;
    logic        w_pingOk;
    logic        w_lastByte;
    logic        w_gapDone;
    logic        w_load;
    logic [7:0]  w_loadByte;
    logic        w_ss;
    logic        w_busy;
    logic        w_done;

    // A "unit" is one shifted chunk: an initial low half with bit 7 on sdo,
    // then one high half and one low half per bit. PING runs 16 bits as a
    // single unit; every other unit is one byte. The unit finishes at the
    // end of the low half that follows its last bit.
    always_comb begin
        w_shifting = (r_state == PING) || (r_state == START) ||
                     (r_state == DATA) || (r_state == END);
        w_halfEnd  = (r_divCnt == DIV_LAST);
        w_unitBits = (r_state == PING) ? 5'd16 : 5'd8;
        w_unitDone = w_shifting && !r_sck && w_halfEnd && (r_bitCnt == w_unitBits);
        w_pingOk   = (r_rx == PING_ACK);
        w_lastByte = ((r_bytesSent + 19'd1) == r_len);
        w_gapDone  = (r_gapCnt == GAP_LAST);
    end

    // State register.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. GAP always separates frames; r_gapNext remembers
    // which frame (or DONE) follows it.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:      if (start_i)      w_nextState = PING;
            PING:      if (w_unitDone)   w_nextState = GAP;
            START:     if (w_unitDone)   w_nextState = (r_len == 19'd0) ? GAP : WAIT_BYTE;
            WAIT_BYTE: if (byte_valid_i) w_nextState = DATA;
            DATA:      if (w_unitDone)   w_nextState = w_lastByte ? GAP : WAIT_BYTE;
            END:       if (w_unitDone)   w_nextState = GAP;
            GAP:       if (w_gapDone)    w_nextState = r_gapNext;
            DONE:                        w_nextState = IDLE;
            default:                     w_nextState = IDLE;
        endcase
    end

    // Output decode. SS stays low across WAIT_BYTE so the whole payload
    // belongs to the 0x61 frame.
    always_comb begin
        w_ss   = !(w_shifting || (r_state == WAIT_BYTE));
        w_busy = (r_state != IDLE) && (r_state != DONE);
        w_done = (r_state == DONE);
    end

    // Entering a shifting state from any other state starts a new unit
    // with its first bit already on sdo.
    always_comb begin
        w_load = (w_nextState != r_state) &&
                 ((w_nextState == PING) || (w_nextState == START) ||
                  (w_nextState == DATA) || (w_nextState == END));
        case (w_nextState)
            PING:    w_loadByte = 8'h00;
            START:   w_loadByte = CMD_START;
            END:     w_loadByte = CMD_END;
            default: w_loadByte = byte_i;
        endcase
    end

    // Shift engine and transaction bookkeeping. The transmit register shifts
    // in zeros, so sdo returns low once a unit has been sent and stays low
    // through the PING response clocks, WAIT_BYTE and GAP.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_gapNext   <= IDLE;
            r_len       <= '0;
            r_bytesSent <= '0;
            r_ackErr    <= 1'b0;
            r_divCnt    <= '0;
            r_sck       <= 1'b0;
            r_bitCnt    <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_byteReq   <= 1'b0;
            r_gapCnt    <= '0;
        end else begin
            r_byteReq <= 1'b0;

            if (r_state == IDLE && start_i) begin
                r_len       <= len_i;
                r_bytesSent <= '0;
                r_ackErr    <= 1'b0;
            end

            if (w_load) begin
                r_divCnt <= '0;
                r_sck    <= 1'b0;
                r_bitCnt <= '0;
                r_tx     <= w_loadByte;
            end else if (w_shifting) begin
                if (w_halfEnd) begin
                    r_divCnt <= '0;
                    if (r_sck) begin
                        r_sck    <= 1'b0;
                        r_tx     <= {r_tx[6:0], 1'b0};
                        r_bitCnt <= r_bitCnt + 5'd1;
                    end else if (r_bitCnt != w_unitBits) begin
                        r_sck <= 1'b1;
                        r_rx  <= {r_rx[6:0], sdi_i};
                    end
                end else begin
                    r_divCnt <= r_divCnt + 8'd1;
                end
            end

            if (r_state == GAP) begin
                r_gapCnt <= r_gapCnt + 8'd1;
            end else begin
                r_gapCnt <= '0;
            end

            if (w_unitDone) begin
                case (r_state)
                    PING: begin
                        r_gapNext <= w_pingOk ? START : DONE;
                        if (!w_pingOk) r_ackErr <= 1'b1;
                    end
                    START: begin
                        if (r_len == 19'd0) r_gapNext <= END;
                        else                r_byteReq <= 1'b1;
                    end
                    DATA: begin
                        r_bytesSent <= r_bytesSent + 19'd1;
                        if (w_lastByte) r_gapNext <= END;
                        else            r_byteReq <= 1'b1;
                    end
                    END:     r_gapNext <= DONE;
                    default: r_gapNext <= r_gapNext;
                endcase
            end
        end
    end

`ifdef SPI_PUMP_ECHO_CHECK_EN
    logic [7:0] r_curByte;
    logic [7:0] r_prevByte;
    logic       r_echoErr;

    // The responder echoes each payload byte one byte later, so at the end
    // of payload byte k the received byte must equal byte k-1. Byte 0 has
    // no predecessor and is not checked.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_curByte  <= '0;
            r_prevByte <= '0;
            r_echoErr  <= 1'b0;
        end else begin
            if (r_state == IDLE && start_i) r_echoErr <= 1'b0;
            if (r_state == WAIT_BYTE && byte_valid_i) r_curByte <= byte_i;
            if (r_state == DATA && w_unitDone) begin
                if (r_bytesSent != 19'd0 && r_rx != r_prevByte) r_echoErr <= 1'b1;
                r_prevByte <= r_curByte;
            end
        end
    end

    assign echo_err_o = r_echoErr;
`else
    assign echo_err_o = 1'b0;
`endif

    assign byte_req_o   = r_byteReq;
    assign busy_o       = w_busy;
    assign done_o       = w_done;
    assign ack_err_o    = r_ackErr;
    assign bytes_sent_o = r_bytesSent;
    assign sck_o        = r_sck;
    assign ss_o         = w_ss;
    assign sdo_o        = r_tx[7];

endmodule

// File: tb/tb_spi_pump_master.sv
// ---------------------------------------------------------------------------
// tb_spi_pump_master
//
// Scoreboard bench for spi_pump_master (CLK_DIV=2, SS_GAP=4). applyStimulus
// queues the expected MOSI frames, the responder's MISO frames, the payload
// bytes for the source and the expected end-of-transaction status. It then
// issues start. Independent processes play the SPI slave and the byte
// source. A monitor rebuilds each MOSI frame from the pins and checks it,
// along with the status at every done_o pulse.
// ---------------------------------------------------------------------------
module tb_spi_pump_master;

    localparam int CD = 2;
`ifdef SPI_PUMP_ECHO_CHECK_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    typedef struct {
        int          nbits;
        logic [63:0] bits;
    } frame_t;

    typedef struct {
        logic [18:0] sent;
        logic        ack;
        logic        echo;
        int          reqs;
    } done_t;

    logic        pclk;
    logic        reset;
    logic        start_i;
    logic [18:0] len_i;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_req_o;
    logic        busy_o;
    logic        done_o;
    logic        ack_err_o;
    logic        echo_err_o;
    logic [18:0] bytes_sent_o;
    logic        sck_o;
    logic        ss_o;
    logic        sdo_o;
    logic        sdi_i;

    frame_t      expFrames[$];
    done_t       expDone[$];
    logic [63:0] misoQ[$];
    logic [7:0]  srcBytes[$];

    int total = 0;
    int bad = 0;
    int srcDelay = 0;
    int reqCount = 0;
    int doneCount = 0;
    int doneBase = 0;

    spi_pump_master #(
        .CLK_DIV(CD),
        .SS_GAP (4)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .start_i     (start_i),
        .len_i       (len_i),
        .byte_i      (byte_i),
        .byte_valid_i(byte_valid_i),
        .byte_req_o  (byte_req_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ack_err_o   (ack_err_o),
        .echo_err_o  (echo_err_o),
        .bytes_sent_o(bytes_sent_o),
        .sck_o       (sck_o),
        .ss_o        (ss_o),
        .sdo_o       (sdo_o),
        .sdi_i       (sdi_i)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    // Queue everything one transaction should produce, then pulse start_i.
    // During payload byte k the responder returns byte k-1. During byte 0 it
    // returns 0xEE, a value no checker may flag. corrupt1 makes it return 0x11
    // during byte 1 instead of byte 0.
    task automatic applyStimulus(input int len, input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input logic [7:0] pingResp,
                                 input bit corrupt1, input int delay);
        frame_t      f;
        done_t       d;
        logic [63:0] m;
        logic [7:0]  pb[3];
        logic [7:0]  resp;
        bit          ok;
        pb[0] = b0;
        pb[1] = b1;
        pb[2] = b2;
        ok = (pingResp == 8'h4B);

        misoQ.push_back({8'h00, pingResp, 48'h0});
        f.nbits = 16;
        f.bits  = 64'h0;
        expFrames.push_back(f);

        if (ok) begin
            f.nbits = 8;
            f.bits  = 64'h61;
            m       = 64'h0;
            for (int k = 0; k < len; k++) begin
                f.bits  = {f.bits[55:0], pb[k]};
                f.nbits = f.nbits + 8;
                if (k == 0)                  resp = 8'hEE;
                else if (k == 1 && corrupt1) resp = 8'h11;
                else                         resp = pb[k-1];
                m = {m[55:0], resp};
                srcBytes.push_back(pb[k]);
            end
            m = m << (64 - f.nbits);
            misoQ.push_back(m);
            expFrames.push_back(f);

            f.nbits = 8;
            f.bits  = 64'h62;
            misoQ.push_back(64'h0);
            expFrames.push_back(f);
        end

        d.sent = ok ? 19'(len) : 19'd0;
        d.ack  = !ok;
        d.echo = ECHO_EN && ok && corrupt1 && (len >= 2);
        d.reqs = ok ? len : 0;
        expDone.push_back(d);

        srcDelay = delay;
        doneBase = doneCount;
        @(negedge pclk);
        start_i = 1'b1;
        len_i   = 19'(len);
        @(negedge pclk);
        start_i = 1'b0;
        len_i   = '0;
    endtask

    task automatic waitDone(input int maxCycles);
        int c;
        c = 0;
        while (doneCount == doneBase && c < maxCycles) begin
            @(negedge pclk);
            c++;
        end
        checkOutput("done_seen", 64'(doneCount != doneBase), 64'd1);
        repeat (6) @(negedge pclk);
    endtask

    // SPI slave: on SS fall takes the next MISO word and presents its MSB,
    // then advances one bit on every SCK fall (mode 0).
    initial begin
        logic [63:0] sh;
        logic        pSs;
        logic        pSck;
        sdi_i = 1'b0;
        sh    = '0;
        pSs   = 1'b1;
        pSck  = 1'b0;
        forever begin
            @(negedge pclk);
            if (!reset && pSs && !ss_o) begin
                sh    = (misoQ.size() > 0) ? misoQ.pop_front() : 64'h0;
                sdi_i = sh[63];
            end else if (!reset && !ss_o && pSck && !sck_o) begin
                sh    = sh << 1;
                sdi_i = sh[63];
            end else if (ss_o) begin
                sdi_i = 1'b0;
            end
            pSs  = ss_o;
            pSck = sck_o;
        end
    end

    // Byte source: answers each byte_req_o after srcDelay cycles. While it
    // waits, the master must keep SS low and SCK low.
    initial begin
        int holdBad;
        byte_valid_i = 1'b0;
        byte_i       = '0;
        forever begin
            @(negedge pclk);
            if (byte_req_o && !reset) begin
                holdBad = 0;
                for (int d = 0; d < srcDelay; d++) begin
                    @(negedge pclk);
                    if (ss_o !== 1'b0 || sck_o !== 1'b0) holdBad++;
                end
                if (srcDelay > 0) checkOutput("wait_hold", 64'(holdBad), 64'd0);
                if (srcBytes.size() > 0) begin
                    byte_i       = srcBytes.pop_front();
                    byte_valid_i = 1'b1;
                    @(negedge pclk);
                    byte_valid_i = 1'b0;
                end
            end
        end
    end

    // Monitor: rebuilds MOSI frames from SCK rises, checks SCK high width,
    // and checks the status at each done_o pulse against the scoreboard.
    initial begin
        frame_t      f;
        done_t       d;
        logic [63:0] capBits;
        int          capN;
        int          highCnt;
        logic        prevSs;
        logic        prevSck;
        capBits = '0;
        capN    = 0;
        highCnt = 0;
        prevSs  = 1'b1;
        prevSck = 1'b0;
        forever begin
            @(negedge pclk);
            if (reset) begin
                capBits  = '0;
                capN     = 0;
                highCnt  = 0;
                reqCount = 0;
            end else begin
                if (byte_req_o) reqCount++;
                if (sck_o) highCnt++;
                if (!ss_o && sck_o && !prevSck) begin
                    capBits = {capBits[62:0], sdo_o};
                    capN++;
                end
                if (prevSck && !sck_o) begin
                    checkOutput("sck_high_width", 64'(highCnt), 64'(CD));
                    highCnt = 0;
                end
                if (!prevSs && ss_o) begin
                    checkOutput("frame_expected", 64'(expFrames.size() > 0), 64'd1);
                    if (expFrames.size() > 0) begin
                        f = expFrames.pop_front();
                        checkOutput("frame_bits", 64'(capN), 64'(f.nbits));
                        checkOutput("frame_data", capBits, f.bits);
                    end
                    capBits = '0;
                    capN    = 0;
                end
                if (done_o) begin
                    checkOutput("done_expected", 64'(expDone.size() > 0), 64'd1);
                    if (expDone.size() > 0) begin
                        d = expDone.pop_front();
                        checkOutput("bytes_sent", 64'(bytes_sent_o), 64'(d.sent));
                        checkOutput("ack_err", 64'(ack_err_o), 64'(d.ack));
                        checkOutput("echo_err", 64'(echo_err_o), 64'(d.echo));
                        checkOutput("byte_req_count", 64'(reqCount), 64'(d.reqs));
                        checkOutput("busy_at_done", 64'(busy_o), 64'd0);
                        checkOutput("frames_pending", 64'(expFrames.size()), 64'd0);
                    end
                    reqCount = 0;
                    doneCount++;
                end
            end
            prevSs  = ss_o;
            prevSck = sck_o;
        end
    end

    initial begin
        int   c;
        int   falls;
        logic p;
        reset   = 1'b1;
        start_i = 1'b0;
        len_i   = '0;
        repeat (3) @(negedge pclk);
        checkOutput("rst_ss", 64'(ss_o), 64'd1);
        checkOutput("rst_sck", 64'(sck_o), 64'd0);
        checkOutput("rst_sdo", 64'(sdo_o), 64'd0);
        checkOutput("rst_busy", 64'(busy_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_byte_req", 64'(byte_req_o), 64'd0);
        checkOutput("rst_bytes_sent", 64'(bytes_sent_o), 64'd0);
        checkOutput("rst_errs", 64'({ack_err_o, echo_err_o}), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge pclk);

        $display("[TB] ping ok, len=3, plus ignored start while busy");
        applyStimulus(3, 8'hA5, 8'h3C, 8'hFF, 8'h4B, 1'b0, 0);
        repeat (30) @(negedge pclk);
        start_i = 1'b1;
        len_i   = 19'd5;
        @(negedge pclk);
        start_i = 1'b0;
        len_i   = '0;
        waitDone(4000);

        $display("[TB] bad ping response");
        applyStimulus(3, 8'hA5, 8'h3C, 8'hFF, 8'h00, 1'b0, 0);
        waitDone(4000);

        $display("[TB] len=0");
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 8'h4B, 1'b0, 0);
        waitDone(4000);

        $display("[TB] byte source delayed 20 cycles");
        applyStimulus(2, 8'h5A, 8'hC3, 8'h00, 8'h4B, 1'b0, 20);
        waitDone(4000);

        $display("[TB] echo corrupted during byte 1");
        applyStimulus(3, 8'hA5, 8'h3C, 8'hFF, 8'h4B, 1'b1, 0);
        waitDone(4000);

        $display("[TB] reset mid-payload");
        applyStimulus(3, 8'h12, 8'h34, 8'h56, 8'h4B, 1'b0, 0);
        c = 0;
        while (reqCount < 2 && c < 4000) begin
            @(negedge pclk);
            c++;
        end
        checkOutput("reach_byte1", 64'(reqCount >= 2), 64'd1);
        falls = 0;
        p     = sck_o;
        c     = 0;
        while (falls < 4 && c < 400) begin
            @(negedge pclk);
            c++;
            if (p && !sck_o) falls++;
            p = sck_o;
        end
        checkOutput("byte1_bit4", 64'(falls), 64'd4);
        @(posedge pclk);
        #1 reset = 1'b1;
        @(negedge pclk);
        checkOutput("midrst_ss", 64'(ss_o), 64'd1);
        checkOutput("midrst_sck", 64'(sck_o), 64'd0);
        checkOutput("midrst_busy", 64'(busy_o), 64'd0);
        checkOutput("midrst_bytes_sent", 64'(bytes_sent_o), 64'd0);
        expFrames.delete();
        expDone.delete();
        misoQ.delete();
        srcBytes.delete();
        @(negedge pclk);
        reset = 1'b0;
        repeat (3) @(negedge pclk);

        $display("[TB] clean transaction after reset");
        applyStimulus(2, 8'h81, 8'h7E, 8'h00, 8'h4B, 1'b0, 0);
        waitDone(4000);

        checkOutput("frames_left", 64'(expFrames.size()), 64'd0);
        checkOutput("done_left", 64'(expDone.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_pump_master.md
SPI_PUMP_MASTER -- requirements
Module: spi_pump_master

Interface
REQ-001 Parameter CLK_DIV, default 2, SCK half-period in pclk cycles; legal range 1..255.
REQ-002 Parameter SS_GAP, default 4, pclk cycles SS is held high between frames; legal range 1..255.
REQ-003 pclk  input  1  single clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  one-cycle request to begin a pump transaction.
REQ-006 len_i  input  19  payload byte count, captured on an accepted start_i.
REQ-007 byte_i  input  8  payload byte from the source.
REQ-008 byte_valid_i  input  1  byte_i is valid and answers the outstanding request.
REQ-009 byte_req_o  output  1  one-cycle pulse requesting the next payload byte.
REQ-010 busy_o  output  1  high from accepted start until done.
REQ-011 done_o  output  1  one-cycle pulse at transaction end.
REQ-012 ack_err_o  output  1  sticky; ping response was not 0x4B.
REQ-013 echo_err_o  output  1  sticky; echo mismatch (see Configuration).
REQ-014 bytes_sent_o  output  19  payload bytes fully shifted in the current or last transaction.
REQ-015 sck_o  output  1  SPI clock, mode 0, idle low.
REQ-016 ss_o  output  1  slave select, active low.
REQ-017 sdo_o  output  1  MOSI, MSB first.
REQ-018 sdi_i  input  1  MISO.

Function
REQ-019 States: IDLE, PING, START, DATA, WAIT_BYTE, END, GAP, DONE.
REQ-020 In IDLE, start_i is accepted; it captures len_i, clears ack_err_o, echo_err_o and bytes_sent_o, and enters PING; start_i is ignored while busy_o=1.
REQ-021 Frame timing: ss_o falls; sdo_o presents bit 7 for CLK_DIV cycles with sck_o low; then each bit has sck_o high for CLK_DIV cycles and low for CLK_DIV cycles.
REQ-022 sdo_o changes only on the pclk where sck_o goes low, or at frame start.
REQ-023 sdi_i is sampled on the pclk where sck_o goes high.
REQ-024 After the last bit of a frame, sck_o stays low CLK_DIV cycles, then ss_o rises and is held high SS_GAP cycles (GAP state) before the next frame.
REQ-025 PING frame: transmits 0x00, then 8 further clocks with sdo_o=0, capturing the response byte.
REQ-026 If the ping response is 0x4B, the block proceeds to START; otherwise it sets ack_err_o=1 and goes via GAP to DONE with no pump frames.
REQ-027 START frame: 0x61 followed by the payload in the same frame (ss_o stays low).
REQ-028 Before each payload byte, byte_req_o pulses once and the block enters WAIT_BYTE.
REQ-029 In WAIT_BYTE, sck_o is held low and ss_o low indefinitely until byte_valid_i=1; byte_i is then latched and shifted.
REQ-030 byte_valid_i outside WAIT_BYTE is ignored.
REQ-031 bytes_sent_o increments on completion of each payload byte's 8th bit.
REQ-032 When len=0, the 0x61 frame carries no payload and byte_req_o never pulses.
REQ-033 END frame: a separate frame transmitting 0x62 alone; then GAP, then DONE.
REQ-034 DONE pulses done_o for one cycle, drops busy_o in the same cycle, and returns to IDLE.
REQ-035 len is 19-bit and does not wrap: exactly len payload bytes are sent (maximum 524287).

Reset
REQ-036 On reset, including mid-frame: ss_o=1, sck_o=0, sdo_o=0, byte_req_o=0, busy_o=0, done_o=0, ack_err_o=0, echo_err_o=0, bytes_sent_o=0, state=IDLE; no partial frame completes.

Configuration
REQ-037 Macro SPI_PUMP_ECHO_CHECK_EN: when defined, the byte received during payload byte k (k>=1) is compared with payload byte k-1, and a mismatch sets echo_err_o=1 without aborting.
REQ-038 With the macro defined, the byte received during payload byte 0 is not checked.
REQ-039 Without the macro, the comparison logic is absent and echo_err_o is tied to 0.

Verification
REQ-040 Ping ok, len=3, bytes 0xA5,0x3C,0xFF, CLK_DIV=2, responder returns 0x4B: MOSI frames 0x00,0x00 / 0x61,A5,3C,FF / 0x62; bytes_sent_o=3; done_o pulses once; ack_err_o=0.
REQ-041 Responder returns 0x00 to ping: ack_err_o=1, no 0x61 frame, done_o pulses, byte_req_o never asserts.
REQ-042 len=0: frames 0x00,0x00 / 0x61 / 0x62; bytes_sent_o=0.
REQ-043 byte_valid_i delayed 20 cycles after byte_req_o: sck_o held low and ss_o held low throughout the delay; the payload then resumes correctly.
REQ-044 Reset asserted mid-payload (after bit 4 of byte 1): next cycle ss_o=1, sck_o=0, busy_o=0; a new start then runs a clean transaction.
REQ-045 With SPI_PUMP_ECHO_CHECK_EN, responder echoes 0x11 instead of 0xA5 during byte 1: echo_err_o=1 and the transaction still completes.
